// File: rtl/muldiv_sequencer_pkg.sv
// muldiv_sequencer_pkg: operation and state encodings shared by the multiply/divide sequencer
package muldiv_sequencer_pkg;
  typedef enum logic [1:0] {
    MD_OP_MUL = 2'b00,
    MD_OP_DIV = 2'b01,
    MD_OP_MOD = 2'b10
  } md_op_e;
  typedef enum logic [1:0] {
    MD_ST_IDLE = 2'b00,
    MD_ST_CALC = 2'b01,
    MD_ST_DONE = 2'b10
  } md_state_e;
endpackage

// File: rtl/muldiv_sequencer_if.sv
// muldiv_sequencer_if: request/result bundle between the EXE-stage controller and the sequencer
interface muldiv_sequencer_if #(parameter int WIDTH = 32) ();
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic             flush;
  logic             stall;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             div_by_zero;
  modport master (output start, op, operand_a, operand_b, flush, input stall, done, result, div_by_zero);
  modport slave (input start, op, operand_a, operand_b, flush, output stall, done, result, div_by_zero);
endinterface

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational shift-add (mul) or restoring shift-subtract (div) iteration
module muldiv_step #(parameter int WIDTH = 32) (
  input  logic             div,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] acc_next,
  output logic [WIDTH-1:0] a_next,
  output logic [WIDTH-1:0] b_next
);
  logic [WIDTH:0] sh;
  logic           ge;
  assign sh = {acc, a[WIDTH-1]};
  assign ge = sh >= {1'b0, b};
  // mul: acc += a when multiplier lsb set; div: the quotient bit shifts into the vacated dividend lsb
  always_comb begin
    acc_next = div ? (ge ? sh[WIDTH-1:0] - b : sh[WIDTH-1:0]) : (b[0] ? acc + a : acc);
    a_next   = div ? {a[WIDTH-2:0], ge} : a << 1;
    b_next   = div ? b : b >> 1;
  end
endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: multi-cycle MUL/DIV/MOD unit that stalls the pipeline until its result is ready
import muldiv_sequencer_pkg::*;
module muldiv_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input logic clk,
  input logic rst_n,
  muldiv_sequencer_if.slave bus
);
  md_state_e        state, state_next;
  md_op_e           op_r;
  logic [WIDTH-1:0] acc, a_r, b_r, acc_next, a_next, b_next, result_r;
  logic [CNT_W-1:0] cnt;
  logic             dbz_r, accept, dz, last;
  assign accept = state == MD_ST_IDLE && bus.start && !bus.flush;
  assign dz = (bus.op == MD_OP_DIV || bus.op == MD_OP_MOD) && bus.operand_b == '0;
  assign last = cnt == CNT_W'(WIDTH - 1);
  assign bus.stall = accept || state == MD_ST_CALC;
  assign bus.done = state == MD_ST_DONE;
  assign bus.result = result_r;
  assign bus.div_by_zero = dbz_r;
  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .div      (op_r != MD_OP_MUL),
    .acc      (acc),
    .a        (a_r),
    .b        (b_r),
    .acc_next (acc_next),
    .a_next   (a_next),
    .b_next   (b_next)
  );
  // next state: flush wins everywhere, divide by zero skips straight to DONE
  always_comb begin
    state_next = bus.flush ? MD_ST_IDLE :
                 state == MD_ST_IDLE ? (bus.start ? (dz ? MD_ST_DONE : MD_ST_CALC) : MD_ST_IDLE) :
                 state == MD_ST_CALC ? (last ? MD_ST_DONE : MD_ST_CALC) : MD_ST_IDLE;
  end
  // state register
  always_ff @(posedge clk) state <= !rst_n ? MD_ST_IDLE : state_next;
  // operand latch, iteration datapath and result capture on the way into DONE
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_r     <= MD_OP_MUL;
      acc      <= '0;
      a_r      <= '0;
      b_r      <= '0;
      cnt      <= '0;
      result_r <= '0;
      dbz_r    <= 1'b0;
    end else if (accept) begin
      op_r  <= bus.op == 2'b11 ? MD_OP_MUL : md_op_e'(bus.op);
      acc   <= '0;
      a_r   <= bus.operand_a;
      b_r   <= bus.operand_b;
      cnt   <= '0;
      dbz_r <= dz;
      if (dz) result_r <= bus.op == MD_OP_DIV ? '1 : bus.operand_a;
    end else if (state == MD_ST_CALC && !bus.flush) begin
      acc <= acc_next;
      a_r <= a_next;
      b_r <= b_next;
      cnt <= cnt + 1'b1;
      if (last) result_r <= op_r == MD_OP_DIV ? a_next : acc_next;
    end
  end
endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed vectors with a scoreboard queue checked by a done-driven monitor
module tb_muldiv_sequencer;
  logic clk = 0;
  logic rst_n = 0;
  int cyc = 0;
  int passed = 0;
  int total = 0;
  logic [31:0] rprev;
  typedef struct {
    logic [31:0] res;
    logic        dbz;
    int          s;
    int          lat;
  } exp_t;
  exp_t sb[$];
  exp_t e;
  muldiv_sequencer_if #(.WIDTH(32)) bus ();
  muldiv_sequencer dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
  endtask
  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      if (sb.size() == 0) chk("unexpected_done", 32'(bus.done), 32'd0);
      else begin
        e = sb.pop_front();
        chk("result", bus.result, e.res);
        chk("div_by_zero", 32'(bus.div_by_zero), 32'(e.dbz));
        chk("latency", 32'(cyc - e.s), 32'(e.lat));
      end
    end
  end
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] er, input logic ed, input int lat, input int poke);
    int ns = 0;
    bit seen = 0;
    @(negedge clk);
    bus.start = 1; bus.op = o; bus.operand_a = a; bus.operand_b = b;
    sb.push_back('{er, ed, cyc, lat});
    for (int i = 0; i < 80 && !seen; i++) begin
      if (i > 0) @(negedge clk);
      if (i == 1) bus.start = 0;
      if (poke > 0 && i == poke) begin
        bus.start = 1; bus.op = 2'b01; bus.operand_a = 32'd1000; bus.operand_b = 32'd3;
      end
      if (poke > 0 && i == poke + 1) bus.start = 0;
      #1;
      if (bus.stall) ns++;
      if (bus.done) seen = 1;
    end
    chk("stall_len", 32'(ns), 32'(lat));
    chk("done_seen", 32'(seen), 32'd1);
  endtask
  initial begin
    bus.start = 0; bus.op = 0; bus.operand_a = 0; bus.operand_b = 0; bus.flush = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    #1;
    chk("rst_stall", 32'(bus.stall), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_result", bus.result, 0);
    chk("rst_dbz", 32'(bus.div_by_zero), 0);
    run_op(2'b00, 32'd7, 32'd6, 32'd42, 0, 33, 0);
    run_op(2'b00, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 0, 33, 0);
    run_op(2'b11, 32'd6, 32'd7, 32'd42, 0, 33, 0);
    run_op(2'b01, 32'd100, 32'd7, 32'd14, 0, 33, 0);
    run_op(2'b10, 32'd100, 32'd7, 32'd2, 0, 33, 0);
    run_op(2'b01, 32'd5, 32'd9, 32'd0, 0, 33, 0);
    run_op(2'b10, 32'd5, 32'd9, 32'd5, 0, 33, 0);
    run_op(2'b01, 32'hFFFF_FFFF, 32'h8000_0001, 32'd1, 0, 33, 0);
    run_op(2'b10, 32'hFFFF_FFFF, 32'h8000_0001, 32'h7FFF_FFFE, 0, 33, 0);
    run_op(2'b01, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 1, 0);
    run_op(2'b10, 32'd5, 32'd0, 32'd5, 1, 1, 0);
    rprev = bus.result;
    @(negedge clk);
    bus.start = 1; bus.op = 2'b01; bus.operand_a = 32'd100; bus.operand_b = 32'd7;
    @(negedge clk);
    bus.start = 0;
    repeat (9) @(negedge clk);
    bus.flush = 1;
    @(negedge clk);
    bus.flush = 0;
    #1;
    chk("flush_stall", 32'(bus.stall), 0);
    chk("flush_done", 32'(bus.done), 0);
    repeat (40) @(negedge clk);
    chk("flush_result_hold", bus.result, rprev);
    run_op(2'b00, 32'd3, 32'd3, 32'd9, 0, 33, 0);
    @(negedge clk);
    bus.start = 1; bus.op = 2'b00; bus.operand_a = 32'd7; bus.operand_b = 32'd6;
    @(negedge clk);
    bus.start = 0;
    repeat (19) @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    #1;
    chk("midrst_stall", 32'(bus.stall), 0);
    chk("midrst_done", 32'(bus.done), 0);
    chk("midrst_result", bus.result, 0);
    chk("midrst_dbz", 32'(bus.div_by_zero), 0);
    repeat (40) @(negedge clk);
    run_op(2'b00, 32'd7, 32'd6, 32'd42, 0, 33, 5);
    repeat (5) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
